// File: rtl/boot_ram_loader_if.sv
// rtl/boot_ram_loader_if.sv - host byte stream in, byte-lane boot RAM write port out
interface boot_ram_loader_if #(
    parameter int ADDR_W = 11,
    parameter int LANES  = 4
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [LANES-1:0]  ram_ce;
    logic              ram_wre;
    logic [ADDR_W-1:0] ram_ad;
    logic [7:0]        ram_din;

    modport master (
        output s_data, s_valid,
        input  s_ready, ram_ce, ram_wre, ram_ad, ram_din
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, ram_ce, ram_wre, ram_ad, ram_din
    );
endinterface

// File: rtl/boot_ram_loader.sv
// rtl/boot_ram_loader.sv - framed boot image loader: length/checksum check, lane RAM writes, core hold
module boot_ram_loader #(
    parameter int         ADDR_W    = 11,
    parameter int         LANES     = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_BYTES = 8192
) (
    input  logic                    clk,
    input  logic                    reset,
    boot_ram_loader_if.slave        bus,
    input  logic                    rearm,
    output logic                    cpu_hold,
    output logic                    done,
    output logic [1:0]              err_code
);
    // One spare counter bit so a full image ends at MAX_BYTES instead of wrapping to 0.
    localparam int          CNT_W   = ADDR_W + 3;
    localparam logic [16:0] MAX_LEN = 17'(MAX_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM, ST_DONE, ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic              wre_q, wre_d;
    logic [LANES-1:0]  ce_q, ce_d;
    logic [ADDR_W-1:0] ad_q, ad_d;
    logic [7:0]        din_q, din_d;
    logic              done_q, done_d;
    logic              hold_q, hold_d;
    logic [1:0]        err_q, err_d;

    logic              s_ready;
    logic              accept;
    logic [15:0]       len_full;
    logic              len_bad;
    logic              last_byte;
    logic [7:0]        sum_add;
    logic              parked;

    assign accept    = bus.s_valid & s_ready;
    assign len_full  = {bus.s_data, len_q[7:0]};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_LEN);
    assign last_byte = (16'(cnt_q) == (len_q - 16'd1));
    assign sum_add   = sum_q + bus.s_data;
    assign parked    = (state_q == ST_DONE) || (state_q == ST_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && bus.s_data == SYNC_BYTE) state_d = ST_LEN0;
            ST_LEN0:  if (accept) state_d = ST_LEN1;
            ST_LEN1:  if (accept) state_d = len_bad ? ST_ERROR : ST_DATA;
            ST_DATA:  if (accept && last_byte) state_d = ST_CSUM;
            ST_CSUM:  if (accept) state_d = (sum_add == 8'h00) ? ST_DONE : ST_ERROR;
            ST_DONE,
            ST_ERROR: if (rearm) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = !parked;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        wre_d   = 1'b0;
        ce_d    = '0;
        ad_d    = ad_q;
        din_d   = din_q;
        err_d   = err_q;
        if (accept) begin
            case (state_q)
                ST_LEN0: len_d[7:0] = bus.s_data;
                ST_LEN1: begin
                    len_d[15:8] = bus.s_data;
                    cnt_d       = '0;
                    sum_d       = 8'h00;
                    if (len_bad) err_d = 2'b01;
                end
                ST_DATA: begin
                    // Byte address = cnt_q: low two bits pick the lane, the rest is the word.
                    sum_d = sum_add;
                    cnt_d = cnt_q + CNT_W'(1);
                    wre_d = 1'b1;
                    ce_d  = LANES'(1) << cnt_q[1:0];
                    ad_d  = cnt_q[ADDR_W+1:2];
                    din_d = bus.s_data;
                end
                ST_CSUM: if (sum_add != 8'h00) err_d = 2'b10;
                default: ;
            endcase
        end
        if (parked && rearm) err_d = 2'b00;
        done_d = (state_d == ST_DONE);
        hold_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q  <= 16'd0;
            cnt_q  <= '0;
            sum_q  <= 8'h00;
            wre_q  <= 1'b0;
            ce_q   <= '0;
            ad_q   <= '0;
            din_q  <= 8'h00;
            done_q <= 1'b0;
            hold_q <= 1'b1;
            err_q  <= 2'b00;
        end else begin
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            wre_q  <= wre_d;
            ce_q   <= ce_d;
            ad_q   <= ad_d;
            din_q  <= din_d;
            done_q <= done_d;
            hold_q <= hold_d;
            err_q  <= err_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.ram_wre = wre_q;
    assign bus.ram_ce  = ce_q;
    assign bus.ram_ad  = ad_q;
    assign bus.ram_din = din_q;
    assign done        = done_q;
    assign cpu_hold    = hold_q;
    assign err_code    = err_q;
endmodule

// File: tb/tb_boot_ram_loader.sv
// tb/tb_boot_ram_loader.sv - vector table, random frames and corner sequences for boot_ram_loader
`timescale 1ns/1ps
module tb_boot_ram_loader;
    localparam int ADDR_W    = 11;
    localparam int LANES     = 4;
    localparam int MAX_BYTES = 8192;

    logic       clk = 1'b0;
    logic       reset;
    logic       rearm;
    logic       cpu_hold;
    logic       done;
    logic [1:0] err_code;

    boot_ram_loader_if #(.ADDR_W(ADDR_W), .LANES(LANES)) bus ();

    boot_ram_loader #(
        .ADDR_W(ADDR_W), .LANES(LANES), .SYNC_BYTE(8'hA5), .MAX_BYTES(MAX_BYTES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .rearm(rearm),
        .cpu_hold(cpu_hold), .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               wr_count = 0;
    logic             mon_en = 1'b0;
    logic [LANES-1:0] last_ce;
    logic [ADDR_W-1:0] last_ad;
    logic [7:0]       last_din;
    logic [7:0]       pl_q[$];
    int               gap_pct = 0;

    typedef struct {
        logic [15:0] len;
        logic [31:0] payload;
        logic [7:0]  csum;
        logic        exp_done;
        logic [1:0]  exp_err;
        int          exp_writes;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ram_wre === 1'b1) begin
                wr_count++;
                last_ce  = bus.ram_ce;
                last_ad  = bus.ram_ad;
                last_din = bus.ram_din;
                chk("ce_onehot", $countones(bus.ram_ce), 1);
            end else begin
                chk("ce_quiet", {28'h0, bus.ram_ce}, 0);
            end
        end
    end

    task automatic tick_idle();
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_wre", {31'h0, bus.ram_wre}, 0);
    endtask

    task automatic send(input logic [7:0] b, input bit is_data, input int idx);
        logic [3:0]  oh;
        logic [10:0] ad;
        for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) tick_idle();
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        chk("s_ready", {31'h0, bus.s_ready}, 1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        if (is_data) begin
            oh = 4'b0001 << (idx % 4);
            ad = 11'(idx / 4);
            chk($sformatf("write%0d", idx),
                {8'h0, bus.ram_wre, bus.ram_ce, bus.ram_ad, bus.ram_din},
                {8'h0, 1'b1, oh, ad, b});
        end else begin
            chk("no_write", {27'h0, bus.ram_wre, bus.ram_ce}, 0);
        end
    endtask

    task automatic run_frame(input logic [15:0] len, input logic [7:0] csum, input bit junk,
                             output logic [1:0] err_o, output logic done_o,
                             output logic hold_o, output int writes_o);
        int w0;
        w0 = wr_count;
        if (junk) begin
            send(8'h00, 0, 0); send(8'hFF, 0, 0); send(8'h5A, 0, 0);
        end
        send(8'hA5, 0, 0);
        send(len[7:0], 0, 0);
        send(len[15:8], 0, 0);
        if (!(len == 16'd0 || int'(len) > MAX_BYTES)) begin
            for (int i = 0; i < int'(len); i++) send(pl_q[i], 1, i);
            send(csum, 0, 0);
        end
        err_o    = err_code;
        done_o   = done;
        hold_o   = cpu_hold;
        writes_o = wr_count - w0;
    endtask

    // Outcome straight from the frame rules: {done, err_code}.
    function automatic logic [2:0] ref_outcome(input logic [15:0] len, input logic [7:0] csum);
        int s;
        if (len == 16'd0 || int'(len) > MAX_BYTES) return 3'b001;
        s = csum;
        for (int i = 0; i < int'(len); i++) s += pl_q[i];
        return (s % 256 == 0) ? 3'b100 : 3'b010;
    endfunction

    task automatic do_rearm(input string tag);
        rearm = 1'b1;
        @(posedge clk); #1;
        rearm = 1'b0;
        chk({tag, "_rearm_err"},   {30'h0, err_code}, 0);
        chk({tag, "_rearm_done"},  {31'h0, done}, 0);
        chk({tag, "_rearm_hold"},  {31'h0, cpu_hold}, 1);
        chk({tag, "_rearm_ready"}, {31'h0, bus.s_ready}, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  g_err;
        logic        g_done, g_hold;
        int          g_wr, w0;
        logic [15:0] len;
        logic [7:0]  csum;
        logic [2:0]  expo;

        vecs[0] = '{16'd4,      32'h0000_0513, 8'hE8, 1'b1, 2'b00, 4};
        vecs[1] = '{16'd1,      32'h0000_007F, 8'h00, 1'b0, 2'b10, 1};
        vecs[2] = '{16'd0,      32'h0,         8'h00, 1'b0, 2'b01, 0};
        vecs[3] = '{16'h2001,   32'h0,         8'h00, 1'b0, 2'b01, 0};
        vecs[4] = '{16'd1,      32'h0000_00A5, 8'h5B, 1'b1, 2'b00, 1};
        vecs[5] = '{16'd2,      32'h0000_005B, 8'hA5, 1'b1, 2'b00, 2};
        vecs[6] = '{16'd3,      32'h0003_0201, 8'hFB, 1'b0, 2'b10, 3};

        reset = 1'b1; rearm = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold",  {31'h0, cpu_hold}, 1);
        chk("rst_done",  {31'h0, done}, 0);
        chk("rst_err",   {30'h0, err_code}, 0);
        chk("rst_ready", {31'h0, bus.s_ready}, 1);
        chk("rst_ram",   {bus.ram_wre, bus.ram_ce, bus.ram_ad, bus.ram_din}, 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        foreach (vecs[v]) begin
            pl_q.delete();
            for (int i = 0; i < 4; i++) pl_q.push_back(vecs[v].payload[8*i +: 8]);
            run_frame(vecs[v].len, vecs[v].csum, 1'b1, g_err, g_done, g_hold, g_wr);
            chk($sformatf("vec%0d_done", v),   {31'h0, g_done}, {31'h0, vecs[v].exp_done});
            chk($sformatf("vec%0d_err", v),    {30'h0, g_err},  {30'h0, vecs[v].exp_err});
            chk($sformatf("vec%0d_hold", v),   {31'h0, g_hold}, {31'h0, !vecs[v].exp_done});
            chk($sformatf("vec%0d_writes", v), g_wr, vecs[v].exp_writes);
            chk($sformatf("vec%0d_ready", v),  {31'h0, bus.s_ready}, 0);
            do_rearm($sformatf("vec%0d", v));
        end

        // rearm while a frame is in progress must be ignored
        send(8'hA5, 0, 0);
        rearm = 1'b1; tick_idle(); rearm = 1'b0;
        send(8'h01, 0, 0); send(8'h00, 0, 0);
        send(8'h42, 1, 0); send(8'hBE, 0, 0);
        chk("midrearm_done", {31'h0, done}, 1);
        do_rearm("midrearm");

        gap_pct = 40;
        for (int r = 0; r < 12; r++) begin
            len = 16'($urandom_range(1, 40));
            if (r == 3) len = 16'd0;
            if (r == 7) len = 16'(MAX_BYTES + 1);
            pl_q.delete();
            for (int i = 0; i < 40; i++) pl_q.push_back(8'($urandom));
            csum = 8'($urandom);
            if ($urandom_range(1) == 1) begin
                expo = 3'b000;
                csum = 8'h00;
                for (int i = 0; i < int'(len) && int'(len) <= MAX_BYTES; i++) csum = csum - pl_q[i];
            end
            expo = ref_outcome(len, csum);
            run_frame(len, csum, 1'b0, g_err, g_done, g_hold, g_wr);
            chk($sformatf("rnd%0d_done", r), {31'h0, g_done}, {31'h0, expo[2]});
            chk($sformatf("rnd%0d_err", r),  {30'h0, g_err},  {30'h0, expo[1:0]});
            chk($sformatf("rnd%0d_writes", r), g_wr, (expo[1:0] == 2'b01) ? 0 : int'(len));
            do_rearm($sformatf("rnd%0d", r));
        end
        gap_pct = 0;

        pl_q.delete();
        for (int i = 0; i < MAX_BYTES; i++) pl_q.push_back(8'(i % 256));
        run_frame(16'(MAX_BYTES), 8'h00, 1'b0, g_err, g_done, g_hold, g_wr);
        chk("full_done",   {31'h0, g_done}, 1);
        chk("full_err",    {30'h0, g_err}, 0);
        chk("full_hold",   {31'h0, g_hold}, 0);
        chk("full_writes", g_wr, MAX_BYTES);
        chk("full_last",   {last_ce, last_ad, last_din}, {4'b1000, 11'h7FF, 8'hFF});
        do_rearm("full");

        send(8'hA5, 0, 0); send(8'h00, 0, 0); send(8'h20, 0, 0);
        for (int i = 0; i < 100; i++) send(pl_q[i], 1, i);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_hold",  {31'h0, cpu_hold}, 1);
        chk("midrst_done",  {31'h0, done}, 0);
        chk("midrst_err",   {30'h0, err_code}, 0);
        chk("midrst_ready", {31'h0, bus.s_ready}, 1);
        w0 = wr_count;
        send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 0, 0);
        repeat (20) tick_idle();
        chk("midrst_nowrites", wr_count - w0, 0);
        chk("midrst_hold2", {31'h0, cpu_hold}, 1);
        pl_q.delete();
        pl_q.push_back(8'h42);
        run_frame(16'd1, 8'hBE, 1'b0, g_err, g_done, g_hold, g_wr);
        chk("postrst_done", {31'h0, g_done}, 1);
        chk("postrst_writes", g_wr, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
